// File: rtl/core_config_pkg.sv
// Shared configuration for the CSR controller: FSM state encoding, machine-mode
// CSR addresses, mstatus bit positions and the funct3 operation classes.
package core_config_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP,
        S_T_EPC,
        S_T_CAUSE,
        S_T_TVAL,
        S_T_MSRD,
        S_T_MSWR,
        S_T_VEC,
        S_T_DONE
    } state_t;

    // Low two bits of funct3; bit 2 only selects the immediate form.
    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_rmw.sv
// Combinational read-modify-write for CSR instructions: new value, write
// enable, value returned to rd and illegal-instruction detection.
module csr_rmw
    import core_config_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] src,
    input  logic            rs1_zero,
    input  logic [XLEN-1:0] old,
    input  logic            addr_err,
    output logic            we,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            err
);

    csr_op_t kind;
    logic    wr_attempt;
    logic    unused_imm_sel;

    // src already carries the zero-extended zimm, so imm forms need no special path
    assign unused_imm_sel = op[2];
    assign kind = csr_op_t'(op[1:0]);

    always_comb begin
        wr_attempt = 1'b0;
        wdata      = '0;
        unique case (kind)
            CSR_OP_RW: begin
                wdata      = src;
                wr_attempt = 1'b1;
            end
            CSR_OP_RS: begin
                wdata      = old | src;
                wr_attempt = !rs1_zero;
            end
            CSR_OP_RC: begin
                wdata      = old & ~src;
                wr_attempt = !rs1_zero;
            end
            default: begin
                wdata      = '0;
                wr_attempt = 1'b0;
            end
        endcase
        err   = (kind == CSR_OP_ILL) || addr_err || (wr_attempt && (addr[11:10] == 2'b11));
        we    = wr_attempt && !err;
        rdata = err ? '0 : old;
    end

endmodule

// File: rtl/csr_ctrl.sv
// CSR instruction and trap-entry sequencer driving a synchronous-read CSR file;
// one FSM shared by both paths, traps take priority in IDLE.
module csr_ctrl
    import core_config_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_rs1_zero,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    output logic            trap_done,
    output logic [XLEN-1:0] trap_vector,
    output logic            csr_we,
    output logic [11:0]     csr_wa,
    output logic [XLEN-1:0] csr_wd,
    output logic [11:0]     csr_ra,
    input  logic [XLEN-1:0] csr_rd,
    input  logic            csr_err
);

    state_t          state;
    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic            rz_q;
    logic            addr_err_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;

    logic            rmw_we;
    logic [XLEN-1:0] rmw_wdata;
    logic [XLEN-1:0] rmw_rdata;
    logic            rmw_err;
    logic            we_dec;
    logic [XLEN-1:0] mstatus_new;
    logic [XLEN-1:0] vec_next;
    logic            unused_cause_bit;

    assign unused_cause_bit = cause_q[XLEN-2];

    csr_rmw #(.XLEN(XLEN)) u_rmw (
        .op       (op_q),
        .addr     (addr_q),
        .src      (src_q),
        .rs1_zero (rz_q),
        .old      (csr_rd),
        .addr_err (addr_err_q),
        .we       (rmw_we),
        .wdata    (rmw_wdata),
        .rdata    (rmw_rdata),
        .err      (rmw_err)
    );

    assign req_ready = (state == S_IDLE) && !trap_valid && !rst;

    always_comb begin
        mstatus_new                                 = csr_rd;
        mstatus_new[MSTATUS_MPIE]                   = csr_rd[MSTATUS_MIE];
        mstatus_new[MSTATUS_MIE]                    = 1'b0;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;

        vec_next = {csr_rd[XLEN-1:2], 2'b00};
        if ((csr_rd[1:0] == 2'b01) && cause_q[XLEN-1])
            vec_next = vec_next + {cause_q[XLEN-3:0], 2'b00};
    end

    // Write strobe is decoded from state so WR can use the read data arriving that
    // cycle; rst masks it so an abort suppresses the in-flight write.
    always_comb begin
        we_dec = 1'b0;
        csr_wa = '0;
        csr_wd = '0;
        csr_ra = '0;
        unique case (state)
            S_RD: begin
                csr_ra = addr_q;
                csr_wa = addr_q;
            end
            S_WR: begin
                csr_wa = addr_q;
                csr_wd = rmw_wdata;
                we_dec = rmw_we;
            end
            S_T_EPC: begin
                we_dec = 1'b1;
                csr_wa = CSR_MEPC;
                csr_wd = pc_q;
            end
            S_T_CAUSE: begin
                we_dec = 1'b1;
                csr_wa = CSR_MCAUSE;
                csr_wd = cause_q;
            end
            S_T_TVAL: begin
                we_dec = 1'b1;
                csr_wa = CSR_MTVAL;
                csr_wd = tval_q;
            end
            S_T_MSRD: csr_ra = CSR_MSTATUS;
            S_T_MSWR: begin
                we_dec = 1'b1;
                csr_wa = CSR_MSTATUS;
                csr_wd = mstatus_new;
                csr_ra = CSR_MTVEC;
            end
            default: begin
                we_dec = 1'b0;
            end
        endcase
    end

    assign csr_we = we_dec && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            rz_q        <= 1'b0;
            addr_err_q  <= 1'b0;
            pc_q        <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            trap_done   <= 1'b0;
            trap_vector <= '0;
        end else begin
            trap_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (trap_valid) begin
                        pc_q    <= trap_pc;
                        cause_q <= trap_cause;
                        tval_q  <= trap_tval;
                        state   <= S_T_EPC;
                    end else if (req_valid) begin
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        src_q  <= req_src;
                        rz_q   <= req_rs1_zero;
                        state  <= S_RD;
                    end
                end
                S_RD: begin
                    addr_err_q <= csr_err;
                    state      <= S_WR;
                end
                S_WR: begin
                    resp_valid <= 1'b1;
                    resp_data  <= rmw_rdata;
                    resp_err   <= rmw_err;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_T_EPC:   state <= S_T_CAUSE;
                S_T_CAUSE: state <= S_T_TVAL;
                S_T_TVAL:  state <= S_T_MSRD;
                S_T_MSRD:  state <= S_T_MSWR;
                S_T_MSWR:  state <= S_T_VEC;
                S_T_VEC: begin
                    trap_vector <= vec_next;
                    trap_done   <= 1'b1;
                    state       <= S_T_DONE;
                end
                S_T_DONE:  state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule
